// File: rtl/aes_dec_key_stream_pkg.sv
// Shared AES-128 definitions (package aes_pkg): round count, key type, Rcon table, FSM states.
package aes_pkg;

    localparam int unsigned NR    = 10;
    localparam int unsigned KEY_W = 128;

    typedef logic [KEY_W-1:0] aes_key_t;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StStream
    } aes_state_e;

    // Entry 0 is never used; round r uses RCON[r].
    localparam logic [7:0] RCON [NR+1] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] get_rcon(input logic [3:0] r);
        return RCON[r];
    endfunction

endpackage

// File: rtl/aes_dec_key_stream_if.sv
// Key-in / round-key-out handshake bundle for aes_dec_key_stream.
interface aes_dec_key_stream_if;
    import aes_pkg::*;

    aes_key_t   key_in;
    logic       start;
    logic       busy;
    logic       rk_valid;
    logic       rk_ready;
    aes_key_t   rk_out;
    logic [3:0] rk_round;
    logic       done;

    modport master (
        output key_in, start, rk_ready,
        input  busy, rk_valid, rk_out, rk_round, done
    );

    modport slave (
        input  key_in, start, rk_ready,
        output busy, rk_valid, rk_out, rk_round, done
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Row-major table: byte value v lives at bits [2047-8v -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_idx;

    assign w_idx  = 11'd2047 - {i_byte, 3'b000};
    assign o_byte = SBOX[w_idx -: 8];

endmodule

// File: rtl/aes_dec_key_stream.sv
// Expands an AES-128 key into 11 round keys, then streams them last-to-first for decryption.
module aes_dec_key_stream
    import aes_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    aes_dec_key_stream_if.slave bus
);

    aes_state_e r_state, w_state_d;
    logic [3:0] r_round, w_round_d;
    logic       r_valid, w_valid_d;
    logic       r_done,  w_done_d;
    logic       w_capture;
    logic       w_expand_we;

    aes_key_t   r_buf [NR+1];

    aes_key_t    w_prev;
    aes_key_t    w_next;
    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_temp;
    logic [31:0] w_nw0, w_nw1, w_nw2, w_nw3;

    // One round of key expansion from the previously stored slot.
    assign w_prev = r_buf[r_round - 4'd1];
    assign w_rot  = {w_prev[23:0], w_prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_temp = w_sub ^ {get_rcon(r_round), 24'h000000};
    assign w_nw0  = w_prev[127:96] ^ w_temp;
    assign w_nw1  = w_prev[95:64]  ^ w_nw0;
    assign w_nw2  = w_prev[63:32]  ^ w_nw1;
    assign w_nw3  = w_prev[31:0]   ^ w_nw2;
    assign w_next = {w_nw0, w_nw1, w_nw2, w_nw3};

    always_comb begin
        w_state_d   = r_state;
        w_round_d   = r_round;
        w_valid_d   = r_valid;
        w_done_d    = 1'b0;
        w_capture   = 1'b0;
        w_expand_we = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_capture = 1'b1;
                    w_round_d = 4'd1;
                    w_state_d = StExpand;
                end
            end
            StExpand: begin
                w_expand_we = 1'b1;
                if (r_round == 4'(NR)) begin
                    // Counter already holds NR, which is the first stream index.
                    w_round_d = 4'(NR);
                    w_state_d = StStream;
                end else begin
                    w_round_d = r_round + 4'd1;
                end
            end
            StStream: begin
                if (!r_valid) begin
                    w_valid_d = 1'b1;
                end else if (bus.rk_ready) begin
                    if (r_round == 4'd0) begin
                        w_valid_d = 1'b0;
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_round_d = r_round - 4'd1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_round <= 4'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_round <= w_round_d;
            r_valid <= w_valid_d;
            r_done  <= w_done_d;
        end
    end

    // Key buffer is not reset; outputs are masked by r_valid instead.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf[0] <= bus.key_in;
        end
        if (w_expand_we) begin
            r_buf[r_round] <= w_next;
        end
    end

    assign bus.busy     = (r_state != StIdle);
    assign bus.rk_valid = r_valid;
    assign bus.rk_out   = r_valid ? r_buf[r_round] : '0;
    assign bus.rk_round = r_valid ? r_round : 4'd0;
    assign bus.done     = r_done;

endmodule
